// File: rtl/instr_mem_pkg.sv
// Shared types, boot image and helpers for the instruction memory.
package instr_mem_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam int INSTR_CNT = 16;
  localparam int IMG_IDX_W = $clog2(INSTR_CNT);

  localparam data_t INSTR_IMAGE [INSTR_CNT] = '{
    32'h0000_0013, 32'h0003_02b7, 32'h0042_8293, 32'h0050_0313,
    32'h0000_0000, 32'h0062_82b3, 32'h0062_a023, 32'hdead_beef,
    32'h0000_0001, 32'h1234_5678, 32'h0000_006f, 32'hcafe_f00d,
    32'h0010_0093, 32'h0020_8113, 32'h0031_0193, 32'h0041_8213
  };

  // Words past the end of the image read as zero.
  function automatic data_t image_word(input int unsigned idx);
    logic [IMG_IDX_W-1:0] sel;
    sel = idx[IMG_IDX_W-1:0];
    if (idx < INSTR_CNT) begin
      return INSTR_IMAGE[sel];
    end
    return '0;
  endfunction

  function automatic data_t merge_be(input data_t old_w, input data_t new_w,
                                     input logic [3:0] be);
    data_t res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant read and write bus between a master and a memory slave.
interface naive_bus;
  import instr_mem_pkg::*;

  logic        rd_req;
  logic        rd_gnt;
  addr_t       rd_addr;
  data_t       rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [3:0]  wr_be;
  addr_t       wr_addr;
  data_t       wr_data;

  modport master (output rd_req, rd_addr, wr_req, wr_be, wr_addr, wr_data,
                  input  rd_gnt, rd_data, wr_gnt);
  modport slave  (input  rd_req, rd_addr, wr_req, wr_be, wr_addr, wr_data,
                  output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/instr_mem_rdpipe.sv
// Read-latency pipeline: one or two register stages carrying data plus valid.
module instr_mem_rdpipe #(
  parameter int RD_LAT = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_p0_d, vld_p0_q;
  logic [DATA_W-1:0] data_p0_d, data_p0_q;
  logic              vld_last;
  logic [DATA_W-1:0] data_last;

  always_comb begin
    vld_p0_d  = in_vld;
    data_p0_d = in_data;
  end

  // p0: array-output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      data_p0_q <= data_p0_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              vld_p1_d, vld_p1_q;
    logic [DATA_W-1:0] data_p1_d, data_p1_q;

    always_comb begin
      vld_p1_d  = vld_p0_q;
      data_p1_d = data_p0_q;
    end

    // p1: output register
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1_q  <= 1'b0;
        data_p1_q <= '0;
      end else begin
        vld_p1_q  <= vld_p1_d;
        data_p1_q <= data_p1_d;
      end
    end

    assign vld_last  = vld_p1_q;
    assign data_last = data_p1_q;
  end else begin : g_lat1
    assign vld_last  = vld_p0_q;
    assign data_last = data_p0_q;
  end

  assign out_vld  = vld_last;
  assign out_data = vld_last ? data_last : '0;

endmodule

// File: rtl/instr_mem.sv
// Instruction memory on naive_bus, preloaded from INSTR_IMAGE.
// Writable when INSTR_MEM_WR_EN is defined, otherwise a ROM.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    RD_LAT    = 1,
  parameter addr_t BASE_ADDR = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  naive_bus.slave  bus,
  output logic     oor_err
);

  localparam int    IDX_W = $clog2(DEPTH);
  localparam addr_t SPAN  = addr_t'(DEPTH * 4);

  addr_t            rd_off, wr_off;
  logic             rd_in, wr_in;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  data_t            words [DEPTH];
  data_t            rd_word;
  data_t            rd_data;
  logic             rd_vld;
  logic             oor_d, oor_q;

  assign bus.rd_gnt = bus.rd_req;
  assign bus.wr_gnt = bus.wr_req;

  // Offsets wrap below BASE_ADDR, so one unsigned compare covers both ends.
  always_comb begin
    rd_off  = bus.rd_addr - BASE_ADDR;
    wr_off  = bus.wr_addr - BASE_ADDR;
    rd_in   = rd_off < SPAN;
    wr_in   = wr_off < SPAN;
    rd_idx  = rd_off[IDX_W+1:2];
    wr_idx  = wr_off[IDX_W+1:2];
    rd_word = rd_in ? words[rd_idx] : '0;
  end

`ifdef INSTR_MEM_WR_EN
  logic wr_hit;
  assign wr_hit = bus.wr_req & wr_in;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    data_t word_q = image_word(i);
    data_t word_d;

    always_comb begin
      word_d = word_q;
      if (wr_hit && (wr_idx == IDX_W'(i))) begin
        word_d = merge_be(word_q, bus.wr_data, bus.wr_be);
      end
    end

    always_ff @(posedge clk) begin
      word_q <= word_d;
    end

    assign words[i] = word_q;
  end

  logic unused_bits;
  assign unused_bits = ^{rd_off[1:0], rd_off[31:IDX_W+2],
                         wr_off[1:0], wr_off[31:IDX_W+2], rd_vld};
`else
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign words[i] = image_word(i);
  end

  logic unused_bits;
  assign unused_bits = ^{rd_off[1:0], rd_off[31:IDX_W+2],
                         wr_off[1:0], wr_off[31:IDX_W+2], wr_idx,
                         bus.wr_data, bus.wr_be, rd_vld};
`endif

  always_comb begin
    oor_d = oor_q | (bus.rd_req & ~rd_in) | (bus.wr_req & ~wr_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end

  assign oor_err = oor_q;

  instr_mem_rdpipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (32)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (bus.rd_req),
    .in_data  (rd_word),
    .out_vld  (rd_vld),
    .out_data (rd_data)
  );

  assign bus.rd_data = rd_data;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: RD_LAT=1, RD_LAT=2 and an offset-base small instance.
module tb_instr_mem;

`ifdef INSTR_MEM_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  localparam logic [31:0] W0  = 32'h0000_0013;
  localparam logic [31:0] W1  = 32'h0003_02b7;
  localparam logic [31:0] W2  = 32'h0042_8293;
  localparam logic [31:0] W15 = 32'h0041_8213;

  logic clk = 1'b0;
  logic rst;
  logic oor1, oor2, oor3;
  int   n_cmp, n_err;

  always #5 clk = ~clk;

  naive_bus bus1 ();
  naive_bus bus2 ();
  naive_bus bus3 ();

  instr_mem #(.DEPTH(256), .RD_LAT(1), .BASE_ADDR(32'h0000_0000)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .oor_err(oor1));
  instr_mem #(.DEPTH(256), .RD_LAT(2), .BASE_ADDR(32'h0000_0000)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .oor_err(oor2));
  instr_mem #(.DEPTH(16), .RD_LAT(1), .BASE_ADDR(32'h0000_1000)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .oor_err(oor3));

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus1.rd_req = 1'b0; bus1.rd_addr = '0; bus1.wr_req = 1'b0;
    bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_be = '0;
    bus2.rd_req = 1'b0; bus2.rd_addr = '0; bus2.wr_req = 1'b0;
    bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_be = '0;
    bus3.rd_req = 1'b0; bus3.rd_addr = '0; bus3.wr_req = 1'b0;
    bus3.wr_addr = '0; bus3.wr_data = '0; bus3.wr_be = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_all();
    nxt(); nxt();
    check_eq("rst_rd1", bus1.rd_data, 32'h0);
    check_eq("rst_rd2", bus2.rd_data, 32'h0);
    check_eq("rst_oor1", 32'(oor1), 32'h0);
    check_eq("rst_oor2", 32'(oor2), 32'h0);
    check_eq("rst_oor3", 32'(oor3), 32'h0);
    rst = 1'b0;

    // RD_LAT=1 basic read and ignored low address bits
    bus1.rd_req = 1'b1; bus1.rd_addr = 32'h4;
    #1;
    check_eq("rd_gnt1", 32'(bus1.rd_gnt), 32'h1);
    check_eq("wr_gnt1_idle", 32'(bus1.wr_gnt), 32'h0);
    nxt();
    bus1.rd_req = 1'b0;
    check_eq("lat1_w1", bus1.rd_data, W1);
    nxt();
    check_eq("lat1_idle", bus1.rd_data, 32'h0);
    bus1.rd_req = 1'b1; bus1.rd_addr = 32'hB;
    nxt();
    bus1.rd_req = 1'b0;
    check_eq("lat1_lowbits", bus1.rd_data, W2);

    // RD_LAT=2 back-to-back
    nxt();
    bus2.rd_req = 1'b1; bus2.rd_addr = 32'h0;
    nxt();
    bus2.rd_addr = 32'h4;
    check_eq("lat2_early", bus2.rd_data, 32'h0);
    nxt();
    bus2.rd_addr = 32'h8;
    check_eq("lat2_w0", bus2.rd_data, W0);
    nxt();
    bus2.rd_req = 1'b0;
    check_eq("lat2_w1", bus2.rd_data, W1);
    nxt();
    check_eq("lat2_w2", bus2.rd_data, W2);
    nxt();
    check_eq("lat2_idle", bus2.rd_data, 32'h0);
    bus2.rd_req = 1'b1; bus2.rd_addr = 32'h40;
    nxt();
    bus2.rd_addr = 32'h3FC;
    nxt();
    bus2.rd_req = 1'b0;
    check_eq("beyond_image", bus2.rd_data, 32'h0);
    nxt();
    check_eq("last_word", bus2.rd_data, 32'h0);
    check_eq("oor2_inrange", 32'(oor2), 32'h0);

    // Out-of-range read and sticky flag
    bus1.rd_req = 1'b1; bus1.rd_addr = 32'h400;
    #1;
    check_eq("oor1_pre", 32'(oor1), 32'h0);
    nxt();
    bus1.rd_addr = 32'h4;
    check_eq("oor_rd_data", bus1.rd_data, 32'h0);
    check_eq("oor1_set", 32'(oor1), 32'h1);
    nxt();
    bus1.rd_req = 1'b0;
    check_eq("oor_then_w1", bus1.rd_data, W1);
    check_eq("oor1_sticky", 32'(oor1), 32'h1);
    nxt();
    check_eq("oor1_sticky2", 32'(oor1), 32'h1);

    // Reset with a read in flight on RD_LAT=2
    bus2.rd_req = 1'b1; bus2.rd_addr = 32'h4;
    nxt();
    bus2.rd_req = 1'b0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    check_eq("flush_rd2", bus2.rd_data, 32'h0);
    check_eq("oor1_cleared", 32'(oor1), 32'h0);
    nxt();
    check_eq("flush_rd2_b", bus2.rd_data, 32'h0);
    bus2.rd_req = 1'b1; bus2.rd_addr = 32'h4;
    nxt();
    bus2.rd_req = 1'b0;
    nxt();
    check_eq("mem_intact", bus2.rd_data, W1);

    // Byte-enable write then read back
    bus1.wr_req = 1'b1; bus1.wr_addr = 32'h10;
    bus1.wr_data = 32'hAABB_CCDD; bus1.wr_be = 4'b0101;
    #1;
    check_eq("wr_gnt1", 32'(bus1.wr_gnt), 32'h1);
    nxt();
    bus1.wr_req = 1'b0;
    bus1.rd_req = 1'b1; bus1.rd_addr = 32'h12;
    nxt();
    bus1.rd_req = 1'b0;
    check_eq("be_write", bus1.rd_data, WR_EN ? 32'h00BB_00DD : 32'h0);

    // Same-cycle read and write returns old data
    nxt();
    bus1.rd_req = 1'b1; bus1.rd_addr = 32'h20;
    bus1.wr_req = 1'b1; bus1.wr_addr = 32'h20;
    bus1.wr_data = 32'h2; bus1.wr_be = 4'b1111;
    nxt();
    bus1.wr_req = 1'b0;
    check_eq("rdw_old", bus1.rd_data, 32'h1);
    nxt();
    bus1.rd_req = 1'b0;
    check_eq("rdw_new", bus1.rd_data, WR_EN ? 32'h2 : 32'h1);

    // Non-zero base, small depth
    nxt();
    bus3.rd_req = 1'b1; bus3.rd_addr = 32'h1004;
    nxt();
    bus3.rd_addr = 32'h103C;
    check_eq("base_w1", bus3.rd_data, W1);
    nxt();
    bus3.rd_req = 1'b0;
    check_eq("base_top", bus3.rd_data, W15);
    check_eq("oor3_clean", 32'(oor3), 32'h0);
    bus3.wr_req = 1'b1; bus3.wr_addr = 32'h0FFC;
    bus3.wr_data = 32'hFFFF_FFFF; bus3.wr_be = 4'b1111;
    nxt();
    bus3.wr_req = 1'b0;
    check_eq("oor3_wr_below", 32'(oor3), 32'h1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    check_eq("oor3_rst", 32'(oor3), 32'h0);
    bus3.rd_req = 1'b1; bus3.rd_addr = 32'h1040;
    nxt();
    bus3.rd_req = 1'b0;
    check_eq("oor3_rd_data", bus3.rd_data, 32'h0);
    check_eq("oor3_rd_above", 32'(oor3), 32'h1);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 256: word count; power of two, 16..16384.
REQ-002 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
REQ-004 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port bus  naive_bus.slave  -: uses rd_req, rd_gnt, rd_addr[31:0], rd_data[31:0], wr_req, wr_gnt, wr_be[3:0], wr_addr[31:0], wr_data[31:0].
REQ-007 SHALL have port oor_err  output  1: sticky flag, set by any out-of-range access.

Function
REQ-008 SHALL drive rd_gnt = rd_req and wr_gnt = wr_req combinationally; no stalls.
REQ-009 SHALL compute word index = (addr - BASE_ADDR) >> 2; an access is in range when the byte offset is < DEPTH*4.
REQ-010 SHALL ignore address bits [1:0] on both reads and writes.
REQ-011 SHALL, for RD_LAT=1, present rd_data one cycle after rd_req: the word at the index when in range, otherwise 32'h0.
REQ-012 SHALL, for RD_LAT=2, capture into an array-output register, then an output register; rd_data is valid two cycles after rd_req, and back-to-back requests are accepted every cycle.
REQ-013 SHALL drive rd_data to 32'h0 in every cycle whose corresponding request slot (RD_LAT cycles earlier) had rd_req=0.
REQ-014 SHALL, when a read and a write hit the same word in the same cycle, return the pre-write (old) data.
REQ-015 SHALL set oor_err at the clock edge after any out-of-range rd_req or wr_req; it then holds at 1 until rst.
REQ-016 SHALL preload contents from the package constant INSTR_IMAGE; words beyond the image length are 32'h0.

Reset
REQ-017 SHALL, on rst, clear rd_data, all pipeline registers and oor_err to 0 at the next edge.
REQ-018 SHALL, on rst, preserve memory contents.
REQ-019 SHALL discard any read in flight when rst asserts; the first rd_data after reset release reflects only post-reset requests.

Configuration
REQ-020 SHALL have macro INSTR_MEM_WR_EN: when defined, an in-range wr_req writes each byte lane whose wr_be bit is 1 at the clock edge.
REQ-021 SHALL, when INSTR_MEM_WR_EN is undefined, act as a ROM: wr_gnt is still asserted, writes are discarded, and out-of-range writes still set oor_err.

Structure
REQ-022 SHALL take INSTR_IMAGE (array of 32-bit words), INSTR_CNT, and the addr/data typedefs from package instr_mem_pkg.
REQ-023 SHALL place the read-latency stage in sub-module instr_mem_rdpipe, parametrised by RD_LAT, carrying data and a valid bit.

Verification
REQ-024 SHALL cover: RD_LAT=1, image word 1 = 32'h000302b7, rd_req at addr 0x4 -> rd_data = 32'h000302b7 one cycle later, then 0 on the following idle cycle.
REQ-025 SHALL cover: RD_LAT=2, reads to 0x0, 0x4, 0x8 in consecutive cycles -> image words 0, 1, 2 on three consecutive cycles starting 2 cycles after the first request.
REQ-026 SHALL cover: DEPTH=256, read at 0x400 -> rd_data = 0 and oor_err = 1 from the next cycle; oor_err stays 1 across later in-range reads until rst.
REQ-027 SHALL cover: WR_EN defined, write 32'hAABBCCDD with be=4'b0101 to 0x10 holding 0 -> read returns 32'h00BB00DD; with WR_EN undefined -> read returns 0.
REQ-028 SHALL cover: WR_EN defined, read and write to 0x20 in the same cycle (old 32'h1, new 32'h2) -> rd_data = 32'h1; next read = 32'h2.
REQ-029 SHALL cover: RD_LAT=2, rst asserted one cycle after rd_req -> rd_data = 0 at the cycle it would have appeared; memory contents are intact afterwards.
